// File: rtl/rfdp_rd_pkg.sv
// Shared types and latency constants for the feature-map buffer read streamer.
// Latency: RD_LAT is 1 by default, or 2 when RFDP_RD_LAT2_EN is defined.
// Backpressure: FIFO_DEPTH = RD_LAT+1 bounds outstanding reads plus queued words.
package rfdp_rd_pkg;

`ifdef RFDP_RD_LAT2_EN
  // Buffer built with an output register: two cycles from read enable to data.
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // One slot per read in flight plus one so a stalled head word never blocks issue.
  localparam int FIFO_DEPTH = RD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rfdp_rd_skid_fifo.sv
// Small register FIFO absorbing SRAM read data while the stream is stalled.
// Latency: a pushed word is visible at dout the cycle after push (head is registered storage).
// Backpressure: none internally; the producer guarantees push never hits a full FIFO.
module rfdp_rd_skid_fifo #(
  parameter int W  = 8,
  parameter int D  = 2,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // Pointer advance with explicit wrap so D need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/rfdp_rd_stream.sv
// Burst read streamer: drives a 1W1R buffer read port and emits words on valid/ready (RFDP_RD_LAT2_EN selects RD_LAT=2).
// Latency: first beat RD_LAT+2 cycles after command acceptance, then 1 word/cycle.
// Backpressure: reads are throttled so in-flight plus queued words never exceed FIFO_DEPTH; resumes same cycle as m_ready.
module rfdp_rd_stream
  import rfdp_rd_pkg::*;
#(
  parameter int WWORD = 1024,
  parameter int WADDR = 12,
  parameter int DEPTH = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WADDR-1:0] cmd_base,
  input  logic [WADDR:0]   cmd_len,
  output logic [WADDR-1:0] aa,
  output logic             cena,
  input  logic [WWORD-1:0] qa,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WWORD-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_e        state;
  logic [WADDR-1:0] addr;
  logic [WADDR-1:0] aa_q;
  logic [WADDR:0]   remain;
  logic [WADDR:0]   len_q;
  logic [WADDR:0]   beat_cnt;
  logic [RD_LAT-1:0] tag;
  logic [CW-1:0]    fcount;
  logic [CW-1:0]    inflight;
  logic [CW:0]      occ;
  logic [WWORD:0]   fdout;
  logic             issue;
  logic             pop;
  logic             push;
  logic             flast;
  logic             done_q;

  assign pop   = m_valid && m_ready;
  assign push  = tag[RD_LAT-1];
  assign flast = (beat_cnt == len_q - 1'b1);

  // Count reads whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag[i]);
  end

  // Pop-aware occupancy lets a read issue in the same cycle a stalled word drains.
  assign occ   = (CW+1)'(inflight) + (CW+1)'(fcount) - (CW+1)'(pop);
  assign issue = (state == ISSUE) && (occ < (CW+1)'(FIFO_DEPTH));

  assign cena      = ~issue;
  assign aa        = issue ? addr : aa_q;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign m_valid   = (fcount != '0);
  assign m_data    = fdout[WWORD-1:0];
  assign m_last    = fdout[WWORD];

  // Control FSM: command capture, address/remaining counters, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      aa_q   <= '0;
      remain <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state  <= ISSUE;
              addr   <= cmd_base;
              remain <= cmd_len;
              len_q  <= cmd_len;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            aa_q   <= addr;
            addr   <= (addr == WADDR'(DEPTH - 1)) ? '0 : addr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == (WADDR+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid-tag pipeline mirrors the SRAM latency; beat counter marks the burst's final word on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag      <= '0;
      beat_cnt <= '0;
    end else begin
      tag[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
      if (state == IDLE) beat_cnt <= '0;
      else if (push)     beat_cnt <= beat_cnt + 1'b1;
    end
  end

  rfdp_rd_skid_fifo #(
    .W  (WWORD + 1),
    .D  (FIFO_DEPTH),
    .CW (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({flast, qa}),
    .pop   (pop),
    .dout  (fdout),
    .count (fcount)
  );

endmodule

// File: tb/tb_rfdp_rd_stream.sv
// Bench for rfdp_rd_stream: small non-power-of-two buffer model with RD_LAT read pipeline.
// Latency: expected beat/done cycles derived from RD_LAT; data from a buffer image indexed base+i mod DEPTH.
// Backpressure: random m_ready including a 10-cycle stall; checks ordering, stability and occupancy.
module tb_rfdp_rd_stream;

  localparam int WWORD      = 32;
  localparam int WADDR      = 5;
  localparam int DEPTH      = 20;
  localparam int RD_LAT     = rfdp_rd_pkg::RD_LAT;
  localparam int FIFO_DEPTH = RD_LAT + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WADDR-1:0] cmd_base;
  logic [WADDR:0]   cmd_len;
  logic [WADDR-1:0] aa;
  logic             cena;
  logic [WWORD-1:0] qa;
  logic             m_valid;
  logic             m_ready;
  logic [WWORD-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  int ncmp  = 0;
  int nfail = 0;

  logic [WWORD-1:0] mem  [32];
  logic [WWORD-1:0] pipe [RD_LAT];

  always #5 clk = ~clk;

  // Buffer read port model: data appears RD_LAT cycles after cena low.
  always @(posedge clk) begin
    if (!cena) pipe[0] <= mem[aa];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign qa = pipe[RD_LAT-1];

  rfdp_rd_stream #(
    .WWORD (WWORD),
    .WADDR (WADDR),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .aa        (aa),
    .cena      (cena),
    .qa        (qa),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    chk({nm, "_cena"},      cena,      1);
    chk({nm, "_aa"},        aa,        0);
    chk({nm, "_m_valid"},   m_valid,   0);
    chk({nm, "_m_data"},    m_data,    0);
    chk({nm, "_m_last"},    m_last,    0);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_done"},      done,      0);
  endtask

  // rmode 0: m_ready held high with latency checks; rmode 1: random m_ready, 10-cycle stall, junk commands while busy.
  task automatic burst(input int base, input int len, input int rmode);
    int cyc, got, issued, first_c, last_c, done_c;
    logic stall, pl, hs;
    logic [WWORD-1:0] pd;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_base  = WADDR'(base);
    cmd_len   = (WADDR+1)'(len);
    m_ready   = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; got = 0; issued = 0; first_c = -1; last_c = -1; done_c = -1;
    stall = 1'b0; pl = 1'b0; pd = '0;
    while (cyc <= 300) begin
      if (rmode == 0)                m_ready = 1'b1;
      else if (cyc >= 4 && cyc < 14) m_ready = 1'b0;
      else                           m_ready = 1'($urandom_range(0, 1));
      if (rmode != 0 && got < len && $urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1;
        cmd_base  = WADDR'($urandom_range(0, DEPTH - 1));
        cmd_len   = (WADDR+1)'($urandom_range(0, DEPTH));
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (done) begin
        done_c = cyc;
        break;
      end
      if (cyc == 1) chk("busy_after_accept", busy, 1);
      if (!cena) begin
        chk("rd_addr", aa, (base + issued) % DEPTH);
        issued++;
        chk("rd_not_excess", issued <= len, 1);
      end
      hs = m_valid && m_ready;
      chk("occupancy_bound", (issued - got - int'(hs)) <= FIFO_DEPTH, 1);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data",  m_data,  pd);
        chk("stall_last",  m_last,  pl);
      end
      if (hs) begin
        chk("beat_in_range", got < len, 1);
        chk("beat_data", m_data, mem[(base + got) % DEPTH]);
        chk("beat_last", m_last, got == len - 1);
        if (got == 0)       first_c = cyc;
        if (got == len - 1) last_c  = cyc;
        got++;
      end
      stall = m_valid && !m_ready;
      pd    = m_data;
      pl    = m_last;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen",   done_c > 0, 1);
    chk("beats_total", got,    len);
    chk("reads_total", issued, len);
    if (done_c > 0) chk("idle_at_done", cmd_ready, 1);
    if (rmode == 0) begin
      chk("first_beat_cycle", first_c, 2 + RD_LAT);
      chk("last_beat_cycle",  last_c,  1 + RD_LAT + len);
      chk("done_cycle",       done_c,  2 + RD_LAT + len);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    m_ready   = 1'b1;
    #1;
    chk("done_single_pulse", done, 0);
  endtask

  initial begin
    int b;
    rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; m_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst_init");
    rst = 1'b0;

    // Basic burst from address 0 with full throughput and latency checks.
    burst(0, 8, 0);

    // Wrap at the end of a non-power-of-two buffer.
    burst(DEPTH - 2, 4, 0);

    // Backpressure with random ready and a long stall.
    burst($urandom_range(0, DEPTH - 1), 16, 1);

    // Zero-length command: accepted, immediate done, no reads or beats.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = WADDR'(7); cmd_len = '0;
    #1;
    chk("zl_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("zl_done",      done,      1);
    chk("zl_cmd_ready", cmd_ready, 1);
    chk("zl_cena",      cena,      1);
    chk("zl_m_valid",   m_valid,   0);
    @(negedge clk);
    #1;
    chk("zl_done_once", done,    0);
    chk("zl_cena_next", cena,    1);
    chk("zl_m_valid_n", m_valid, 0);

    // Reset three cycles into a full-depth burst, then a short recovery burst.
    b = $urandom_range(0, DEPTH - 1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = WADDR'(b); cmd_len = (WADDR+1)'(DEPTH); m_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_rst_m_valid", m_valid, 0);
      chk("post_rst_done",    done,    0);
      chk("post_rst_cena",    cena,    1);
    end
    burst(b, 2, 0);

    // Random bursts, including a full-depth one under backpressure.
    for (int k = 0; k < 4; k++)
      burst($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), $urandom_range(0, 1));
    burst(5, DEPTH, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
